instruction_fetch_unit: RTL and testbench

- Sequences the instruction memory read port. Owns the program counter and issues fetch addresses.
- Buffers fetched words in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects from execute.
- Stops fetching on the all-zero end-of-program word.
- Sits between the instruction memory (combinational read: address in, instruction out the same cycle) and the decode stage.

---
 rtl/instruction_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Owns the program counter and drives the instruction memory read
//            port. Fetched words go into a small prefetch FIFO that feeds
//            decode over a valid/ready handshake. Execute can redirect the PC.
//            Fetching stops on the all-zero end-of-program word.
// Revision : 1.0  initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    INST_WIDTH = 19,
    parameter int                    DEPTH      = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [INST_WIDTH-1:0] imem_instruction,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  halted
);

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   pc_next;

    logic [INST_WIDTH-1:0]   fifo_inst [DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_pc   [DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        count;

    logic                    pop;
    logic                    fetch_ok;
    logic                    end_word;
    logic                    push;

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign imem_address = pc;
    assign inst_valid   = (count != '0);
    assign pop          = inst_valid & inst_ready;

    // A slot is available when not full, or when full but the head leaves
    // this same cycle. A redirect suppresses the fetch of the stale path.
    assign fetch_ok = (state == RUN) & ~redirect & ((count < FULL) | pop);
    assign end_word = fetch_ok & (imem_instruction == '0);
    assign push     = fetch_ok & ~end_word;

    // Head is forced to zero while empty so stale entries never leak out.
    assign inst_out = inst_valid ? fifo_inst[rd_ptr] : '0;
    assign inst_pc  = inst_valid ? fifo_pc[rd_ptr]   : '0;
    assign halted   = (state == HALT) & (count == '0);

    // Next PC and run/halt state; redirect beats any fetch decision.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (redirect) begin
            state_next = RUN;
            pc_next    = redirect_target;
        end else if (push) begin
            pc_next = pc + ADDR_WIDTH'(1);
        end else if (end_word) begin
            state_next = HALT;
        end
    end

    // PC and state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // FIFO pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clock) begin
        if (reset || redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: the fetched word together with the address it came from.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_inst[wr_ptr] <= imem_instruction;
            fifo_pc[wr_ptr]   <= pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Self-checking bench for instruction_fetch_unit: directed
//            scenarios pinned with literal values, then randomized traffic,
//            all compared every cycle against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int AW    = 12;
    localparam int IW    = 19;
    localparam int DEPTH = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          inst_ready;
    logic          redirect;
    logic [AW-1:0] redirect_target;
    logic [AW-1:0] imem_address;
    logic [IW-1:0] imem_instruction;
    logic [IW-1:0] inst_out;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic          halted;

    logic [IW-1:0] mem [0:4095];

    int tests  = 0;
    int failed = 0;

    // Reference model: FIFO as a queue of (pc, word), plus PC and halt flag.
    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] w;
    } ent_t;
    ent_t          q[$];
    logic [AW-1:0] m_pc;
    bit            m_halt;

    always #5 clock = ~clock;

    assign imem_instruction = mem[imem_address];

    instruction_fetch_unit #(
        .ADDR_WIDTH(AW),
        .INST_WIDTH(IW),
        .DEPTH     (DEPTH),
        .RESET_PC  ('0)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_address    (imem_address),
        .imem_instruction(imem_instruction),
        .inst_out        (inst_out),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halted          (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit   do_pop;
        ent_t e;
        if (reset) begin
            q.delete();
            m_pc   = '0;
            m_halt = 0;
        end else if (redirect) begin
            q.delete();
            m_pc   = redirect_target;
            m_halt = 0;
        end else begin
            do_pop = (q.size() > 0) && inst_ready;
            if (do_pop) void'(q.pop_front());
            if (!m_halt && (q.size() < DEPTH)) begin
                if (mem[m_pc] == '0) begin
                    m_halt = 1;
                end else begin
                    e.pc = m_pc;
                    e.w  = mem[m_pc];
                    q.push_back(e);
                    m_pc = AW'((32'(m_pc) + 1) % 4096);
                end
            end
        end
    endtask

    // Compare every DUT output against the model.
    task automatic check_model();
        bit            v;
        logic [IW-1:0] ew;
        logic [AW-1:0] ep;
        v  = (q.size() > 0);
        ew = v ? q[0].w  : '0;
        ep = v ? q[0].pc : '0;
        chk("imem_address", 32'(imem_address), 32'(m_pc));
        chk("inst_valid",   32'(inst_valid),   32'(v));
        chk("inst_out",     32'(inst_out),     32'(ew));
        chk("inst_pc",      32'(inst_pc),      32'(ep));
        chk("halted",       32'(halted),       32'(m_halt && !v));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check_model();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = IW'(i) | 19'h40000;
        mem[0]  = 19'h01234;
        mem[1]  = 19'h05678;
        mem[2]  = 19'h00001;
        mem[3]  = 19'h00000;
        mem[10] = 19'h00000;

        reset = 1; inst_ready = 1; redirect = 0; redirect_target = '0;
        q.delete(); m_pc = '0; m_halt = 0;
        #2;

        // Straight-line fetch
        cycle();
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_addr",  32'(imem_address), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_out",   32'(inst_out), 0);
        reset = 0;
        cycle();
        chk("sl_pc0",  32'(inst_pc), 0);
        chk("sl_out0", 32'(inst_out), 32'h01234);
        chk("sl_v0",   32'(inst_valid), 1);
        cycle();
        chk("sl_pc1",  32'(inst_pc), 1);
        chk("sl_out1", 32'(inst_out), 32'h05678);
        cycle();
        chk("sl_pc2",  32'(inst_pc), 2);
        chk("sl_out2", 32'(inst_out), 32'h00001);
        chk("sl_addr3", 32'(imem_address), 3);
        cycle();
        chk("sl_halted", 32'(halted), 1);
        chk("sl_valid_end", 32'(inst_valid), 0);
        cycle();
        chk("sl_addr_hold", 32'(imem_address), 3);

        // Backpressure
        reset = 1; cycle(); reset = 0;
        inst_ready = 0;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            if (k >= 2) chk("bp_addr_hold", 32'(imem_address), 2);
        end
        chk("bp_head", 32'(inst_pc), 0);
        inst_ready = 1;
        cycle(); chk("bp_pc1", 32'(inst_pc), 1);
        cycle(); chk("bp_pc2", 32'(inst_pc), 2);
        cycle(); chk("bp_halted", 32'(halted), 1);

        // Redirect with a full FIFO holding pc 4,5
        inst_ready = 0; redirect = 1; redirect_target = 12'd4;
        cycle();
        redirect = 0;
        cycle();
        cycle();
        chk("rf_head4", 32'(inst_pc), 4);
        chk("rf_full_addr", 32'(imem_address), 6);
        redirect = 1; redirect_target = 12'd9; inst_ready = 1;
        cycle();
        chk("rf_valid0", 32'(inst_valid), 0);
        chk("rf_addr9",  32'(imem_address), 9);
        redirect = 0;
        cycle();
        chk("rf_pc9", 32'(inst_pc), 9);
        cycle();
        chk("rf_halt10", 32'(halted), 1);
        chk("rf_addr10", 32'(imem_address), 10);

        // Redirect out of HALT
        redirect = 1; redirect_target = 12'd2;
        cycle();
        chk("rh_halted0", 32'(halted), 0);
        chk("rh_addr2",   32'(imem_address), 2);
        redirect = 0;
        cycle();
        chk("rh_pc2", 32'(inst_pc), 2);
        chk("rh_v",   32'(inst_valid), 1);
        cycle();

        // PC wrap
        redirect = 1; redirect_target = 12'd4094;
        cycle();
        redirect = 0;
        cycle(); chk("wr_4094", 32'(inst_pc), 4094);
        cycle(); chk("wr_4095", 32'(inst_pc), 4095);
        cycle(); chk("wr_0",    32'(inst_pc), 0);
        chk("wr_out0", 32'(inst_out), 32'h01234);

        // Reset mid-operation with a simultaneous redirect
        inst_ready = 0; redirect = 1; redirect_target = 12'd5;
        cycle();
        redirect = 0;
        cycle(); cycle();
        chk("rm_full_head", 32'(inst_pc), 5);
        reset = 1; redirect = 1; redirect_target = 12'd7;
        cycle();
        chk("rm_valid", 32'(inst_valid), 0);
        chk("rm_addr",  32'(imem_address), 0);
        chk("rm_halted", 32'(halted), 0);
        reset = 0; redirect = 0;

        // Randomized traffic
        for (int i = 0; i < 4096; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? '0 : IW'($urandom);
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(0, 149) == 0);
            inst_ready      = ($urandom_range(0, 3) != 0);
            redirect        = ($urandom_range(0, 11) == 0);
            redirect_target = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(4090, 4095))
                                                          : AW'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
